param_pattern_recognizer: RTL and testbench

Generalised serial pattern detector, successor to the fixed two-bit Moore recognizers. Detects a runtime-programmable PATTERN_WIDTH-bit pattern in a 1-bit serial stream with valid qualification. Overlapping or non-overlapping matching is selected at runtime, and a saturating detection counter is kept. It sits between a serial front end (deserialiser or bit sampler) and control logic that consumes the registered detection pulse.

---
 rtl/pattern_recognizer_pkg.sv | 19 +
 rtl/param_pattern_recognizer_sat_counter.sv | 22 ++
 rtl/param_pattern_recognizer.sv | 91 +++++++++
 tb/tb_param_pattern_recognizer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_recognizer_pkg.sv
// Shared types and sizing helpers for the serial pattern recognizer.
// Optional feature macro: PATTERN_RECOGNIZER_MASK_EN.
package pattern_recognizer_pkg;

  localparam logic MODE_NON_OVERLAP = 1'b0;
  localparam logic MODE_OVERLAP     = 1'b1;

  localparam int DEF_PATTERN_WIDTH = 4;
  localparam int DEF_CNT_WIDTH     = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/param_pattern_recognizer_sat_counter.sv
// Saturating up-counter with clear priority over increment.
// Used as the detection counter of param_pattern_recognizer.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/param_pattern_recognizer.sv
// Programmable serial pattern detector with overlap control and match count.
// Optional mask compare enabled by PATTERN_RECOGNIZER_MASK_EN.
module param_pattern_recognizer
  import pattern_recognizer_pkg::*;
#(
  parameter int PATTERN_WIDTH = DEF_PATTERN_WIDTH,
  parameter logic [PATTERN_WIDTH-1:0] DEFAULT_PATTERN = 4'b1011,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift_en,
  input  logic                     shift_in,
  input  logic                     load,
  input  logic [PATTERN_WIDTH-1:0] pattern_in,
`ifdef PATTERN_RECOGNIZER_MASK_EN
  input  logic [PATTERN_WIDTH-1:0] mask_in,
`endif
  input  logic                     overlap_mode,
  input  logic                     clear_count,
  output logic                     detection,
  output logic [CNT_WIDTH-1:0]     det_count,
  output logic                     armed
);

  localparam int FW = clog2(PATTERN_WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_WIDTH);

  logic [PATTERN_WIDTH-1:0] hist;
  logic [PATTERN_WIDTH-1:0] hist_n;
  logic [PATTERN_WIDTH-1:0] pattern_reg;
  logic [FW-1:0]            fill;
  logic [FW-1:0]            fill_n;
  logic                     shift;
  logic                     hit;
  logic                     match;

  assign shift  = shift_en && !load;
  assign hist_n = {hist[PATTERN_WIDTH-2:0], shift_in};
  assign fill_n = (fill == FULL) ? FULL : fill + FW'(1);

`ifdef PATTERN_RECOGNIZER_MASK_EN
  logic [PATTERN_WIDTH-1:0] mask_reg;

  always_ff @(posedge clk) begin
    if (!reset)
      mask_reg <= '1;
    else if (load)
      mask_reg <= mask_in;
  end

  assign hit = ((hist_n ^ pattern_reg) & mask_reg) == '0;
`else
  assign hit = (hist_n == pattern_reg);
`endif

  assign match = shift && (fill_n == FULL) && hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist        <= '0;
      fill        <= '0;
      pattern_reg <= DEFAULT_PATTERN;
      detection   <= 1'b0;
    end else begin
      detection <= match;
      if (load) begin
        pattern_reg <= pattern_in;
        fill        <= '0;
      end else if (shift) begin
        hist <= hist_n;
        // a non-overlapping match restarts collection from scratch
        if (match && (overlap_mode == MODE_NON_OVERLAP))
          fill <= '0;
        else
          fill <= fill_n;
      end
    end
  end

  assign armed = (fill == FULL);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (clear_count),
    .count (det_count)
  );

endmodule

// File: tb/tb_param_pattern_recognizer.sv
// Randomised and directed bench for param_pattern_recognizer.
// A queue-based reference model predicts detection, armed and counts.
module tb_param_pattern_recognizer;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          shift_en = 1'b0;
  logic          shift_in = 1'b0;
  logic          load = 1'b0;
  logic [PW-1:0] pattern_in = '0;
  logic          overlap_mode = 1'b1;
  logic          clear_count = 1'b0;
  logic          detection;
  logic [7:0]    det_count;
  logic          armed;
  logic          detection2;
  logic [1:0]    det_count2;
  logic          armed2;
`ifdef PATTERN_RECOGNIZER_MASK_EN
  logic [PW-1:0] mask_in = '1;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  bit      m_q[$];
  bit [PW-1:0] m_pat;
  bit [PW-1:0] m_mask;
  bit      m_det;
  int      m_cnt;
  int      m_cnt2;

  always #5 clk = ~clk;

  param_pattern_recognizer dut (
    .clk          (clk),
    .reset        (reset),
    .shift_en     (shift_en),
    .shift_in     (shift_in),
    .load         (load),
    .pattern_in   (pattern_in),
`ifdef PATTERN_RECOGNIZER_MASK_EN
    .mask_in      (mask_in),
`endif
    .overlap_mode (overlap_mode),
    .clear_count  (clear_count),
    .detection    (detection),
    .det_count    (det_count),
    .armed        (armed)
  );

  param_pattern_recognizer #(.CNT_WIDTH(2)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .shift_en     (shift_en),
    .shift_in     (shift_in),
    .load         (load),
    .pattern_in   (pattern_in),
`ifdef PATTERN_RECOGNIZER_MASK_EN
    .mask_in      (mask_in),
`endif
    .overlap_mode (overlap_mode),
    .clear_count  (clear_count),
    .detection    (detection2),
    .det_count    (det_count2),
    .armed        (armed2)
  );

  function automatic bit model_hit();
    bit [PW-1:0] v;
    v = '0;
    for (int i = 0; i < PW; i++) v = {v[PW-2:0], m_q[i]};
    return ((v ^ m_pat) & m_mask) == '0;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    shift_en = 1'b0;
    load = 1'b0;
    clear_count = 1'b0;
    @(posedge clk);
    m_q.delete();
    m_pat = 4'b1011;
    m_mask = '1;
    m_det = 1'b0;
    m_cnt = 0;
    m_cnt2 = 0;
    #1 reset = 1'b1;
  endtask

  // Drive one clock of stimulus and advance the model; sample at edge+1.
  task automatic cycle(input bit se, input bit si, input bit ld = 1'b0,
                       input bit [PW-1:0] pi = '0, input bit clr = 1'b0);
    bit m;
    shift_en = se;
    shift_in = si;
    load = ld;
    pattern_in = pi;
    clear_count = clr;
    @(posedge clk);
    m = 1'b0;
    if (ld) begin
      m_pat = pi;
`ifdef PATTERN_RECOGNIZER_MASK_EN
      m_mask = mask_in;
`endif
      m_q.delete();
    end else if (se) begin
      m_q.push_back(si);
      if (m_q.size() > PW) void'(m_q.pop_front());
      m = (m_q.size() == PW) && model_hit();
      if (m && !overlap_mode) m_q.delete();
    end
    m_det = m;
    if (clr) begin
      m_cnt = 0;
      m_cnt2 = 0;
    end else if (m) begin
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end
    #1;
    shift_en = 1'b0;
    load = 1'b0;
    clear_count = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({detection, det_count, armed} !== 10'b0) begin
      errors++;
      $display("FAIL reset got det=%0b cnt=%0d armed=%0b want 0/0/0",
               detection, det_count, armed);
    end
    checks++;
    if ({detection2, det_count2, armed2} !== 4'b0) begin
      errors++;
      $display("FAIL reset2 got det=%0b cnt=%0d armed=%0b want 0/0/0",
               detection2, det_count2, armed2);
    end
  endtask

  task automatic run_stream(input string nm, input bit ov);
    bit [6:0] s;
    s = 7'b1011011;
    do_reset();
    overlap_mode = ov;
    for (int i = 6; i >= 0; i--) begin
      cycle(1'b1, s[i]);
      checks++;
      if (detection !== m_det || armed !== (m_q.size() == PW)) begin
        errors++;
        $display("FAIL %s bit%0d got det=%0b armed=%0b want %0b/%0b",
                 nm, 7 - i, detection, armed, m_det, m_q.size() == PW);
      end
    end
    checks++;
    if (det_count !== 8'(ov ? 2 : 1)) begin
      errors++;
      $display("FAIL %s count got %0d want %0d", nm, det_count, ov ? 2 : 1);
    end
  endtask

  task automatic test_overlap();
    run_stream("overlap", 1'b1);
  endtask

  task automatic test_non_overlap();
    run_stream("nonoverlap", 1'b0);
  endtask

  task automatic test_load();
    bit [3:0] s;
    do_reset();
    overlap_mode = 1'b1;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 4'b0110);
    checks++;
    if (detection !== 1'b0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL load_drop got det=%0b armed=%0b want 0/0",
               detection, armed);
    end
    s = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      cycle(1'b1, s[i]);
      checks++;
      if (detection !== m_det || detection !== (i == 0)) begin
        errors++;
        $display("FAIL load_stream bit%0d got det=%0b want %0b",
                 4 - i, detection, i == 0);
      end
    end
    checks++;
    if (det_count !== 8'd1) begin
      errors++;
      $display("FAIL load_count got %0d want 1", det_count);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    overlap_mode = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 4'b1111);
    for (int i = 1; i <= 7; i++) begin
      cycle(1'b1, 1'b1);
      checks++;
      if (detection2 !== (i >= 4) || det_count2 !== 2'(m_cnt2)) begin
        errors++;
        $display("FAIL sat bit%0d got det=%0b cnt=%0d want %0b/%0d",
                 i, detection2, det_count2, i >= 4, m_cnt2);
      end
    end
    checks++;
    if (det_count2 !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold got %0d want 3", det_count2);
    end
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b1);
    checks++;
    if (det_count2 !== 2'd0 || detection2 !== 1'b1 || det_count !== 8'd0) begin
      errors++;
      $display("FAIL clr_prio got cnt=%0d det=%0b cnt8=%0d want 0/1/0",
               det_count2, detection2, det_count);
    end
  endtask

  task automatic test_gaps();
    bit se[7] = '{1, 1, 0, 0, 0, 1, 1};
    bit si[7] = '{1, 0, 1, 1, 1, 1, 1};
    do_reset();
    overlap_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle(se[i], si[i]);
      checks++;
      if (detection !== m_det || detection !== (i == 6)) begin
        errors++;
        $display("FAIL gaps cyc%0d got det=%0b want %0b",
                 i, detection, i == 6);
      end
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (detection !== 1'b0) begin
      errors++;
      $display("FAIL gaps_width got det=%0b want 0", detection);
    end
  endtask

  task automatic test_midreset();
    bit [3:0] s;
    do_reset();
    overlap_mode = 1'b1;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    do_reset();
    checks++;
    if ({detection, det_count, armed} !== 10'b0) begin
      errors++;
      $display("FAIL midreset got det=%0b cnt=%0d armed=%0b want 0/0/0",
               detection, det_count, armed);
    end
    cycle(1'b1, 1'b1);
    checks++;
    if (detection !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale got det=%0b want 0", detection);
    end
    s = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      cycle(1'b1, s[i]);
      checks++;
      if (detection !== m_det || detection !== (i == 0)) begin
        errors++;
        $display("FAIL midreset_fresh bit%0d got det=%0b want %0b",
                 4 - i, detection, i == 0);
      end
    end
  endtask

`ifdef PATTERN_RECOGNIZER_MASK_EN
  task automatic test_mask();
    bit [3:0] s;
    do_reset();
    overlap_mode = 1'b1;
    mask_in = 4'b1001;
    cycle(1'b0, 1'b0, 1'b1, 4'b1011);
    s = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      cycle(1'b1, s[i]);
      checks++;
      if (detection !== (i == 0)) begin
        errors++;
        $display("FAIL mask bit%0d got det=%0b want %0b",
                 4 - i, detection, i == 0);
      end
    end
    mask_in = '1;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) overlap_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 29) == 0)
        cycle($urandom_range(0, 1), $urandom_range(0, 1), 1'b1,
              PW'($urandom_range(0, 15)));
      else
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), 1'b0, '0,
              $urandom_range(0, 49) == 0);
      checks++;
      if (detection !== m_det || armed !== (m_q.size() == PW) ||
          det_count !== 8'(m_cnt) || det_count2 !== 2'(m_cnt2)) begin
        errors++;
        $display("FAIL random n%0d got %0b/%0b/%0d/%0d want %0b/%0b/%0d/%0d",
                 n, detection, armed, det_count, det_count2,
                 m_det, m_q.size() == PW, m_cnt, m_cnt2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_load();
    test_saturate();
    test_gaps();
    test_midreset();
`ifdef PATTERN_RECOGNIZER_MASK_EN
    test_mask();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
